// File: rtl/sparse_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sparse_enc_pkg
// Brief   : FSM encoding, default geometry and width helpers for the encoder.
// Rev     : 1.0  initial release
// ============================================================================
package sparse_enc_pkg;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int PE_NUM_DEF = 4;
  localparam int W_ROW_DEF  = 16;
  localparam int W_COL_DEF  = 8;
  localparam int L          = W_ROW_DEF / PE_NUM_DEF;
  localparam int NNZ_MAX    = W_ROW_DEF * W_COL_DEF / PE_NUM_DEF;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when an unsigned field of 'bits' bits can hold 'value'.
  function automatic bit fits_bits(input int value, input int bits);
    return $clog2(value + 1) <= bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_weight_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : sparse_weight_encoder_if
// Brief   : Column input and encoded-image output bundle (SPARSE_ENC_THRESH_EN
//           adds prune_thr). Rev 1.0 initial release
// ============================================================================
interface sparse_weight_encoder_if #(
  parameter int PE_NUM = 4,
  parameter int W_ROW  = 16,
  parameter int W_COL  = 8,
  parameter int BW_W   = 8,
  parameter int BW_P   = 7,
  parameter int BW_Z   = 3
);
  localparam int NNZ = W_ROW * W_COL / PE_NUM;

  logic                   col_valid;
  logic                   col_ready;
  logic signed [BW_W-1:0] col_in [W_ROW];
  logic signed [BW_W-1:0] enc_w  [PE_NUM][NNZ];
  logic        [BW_Z-1:0] enc_z  [PE_NUM][NNZ];
  logic        [BW_P-1:0] enc_p  [PE_NUM][W_COL+1];
  logic                   out_valid;
  logic                   out_ready;
`ifdef SPARSE_ENC_THRESH_EN
  logic        [BW_W-2:0] prune_thr;
`endif

  modport master (
`ifdef SPARSE_ENC_THRESH_EN
    output prune_thr,
`endif
    output col_valid, col_in, out_ready,
    input  col_ready, enc_w, enc_z, enc_p, out_valid
  );

  modport slave (
`ifdef SPARSE_ENC_THRESH_EN
    input  prune_thr,
`endif
    input  col_valid, col_in, out_ready,
    output col_ready, enc_w, enc_z, enc_p, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/sparse_enc_lane.sv
`default_nettype none
// ============================================================================
// Module  : sparse_enc_lane
// Brief   : One PE's write pointer, zero-run counter and w/z/p storage.
//           SPARSE_ENC_THRESH_EN enables magnitude pruning. Rev 1.0
// ============================================================================
module sparse_enc_lane
  import sparse_enc_pkg::*;
#(
  parameter int W_COL = W_COL_DEF,
  parameter int BW_W  = 8,
  parameter int BW_P  = 7,
  parameter int BW_Z  = 3,
  parameter int NNZ   = NNZ_MAX,
  localparam int PIDX_W = clog2_min1(W_COL + 1)
) (
  input  wire                     clk,
  input  wire                     reset_n,
  input  wire                     clr_i,
  input  wire                     p_wr_i,
  input  wire        [PIDX_W-1:0] p_idx_i,
  input  wire                     scan_i,
  input  wire                     last_i,
  input  wire                     final_i,
  input  wire logic signed [BW_W-1:0] elem_i,
`ifdef SPARSE_ENC_THRESH_EN
  input  wire        [BW_W-2:0]   thr_i,
`endif
  output logic signed [BW_W-1:0]  enc_w_o [NNZ],
  output logic        [BW_Z-1:0]  enc_z_o [NNZ],
  output logic        [BW_P-1:0]  enc_p_o [W_COL+1]
);
  localparam int WIDX_W = clog2_min1(NNZ);

  logic        [BW_P-1:0]   wptr_q, wptr_d;
  logic        [BW_Z-1:0]   zrun_q, zrun_d;
  logic signed [BW_W-1:0]   enc_w_q [NNZ];
  logic        [BW_Z-1:0]   enc_z_q [NNZ];
  logic        [BW_P-1:0]   enc_p_q [W_COL+1];
  logic                     w_zero;
  logic        [WIDX_W-1:0] w_widx;

`ifdef SPARSE_ENC_THRESH_EN
  // Magnitude as unsigned so that -2^(BW_W-1) maps to 2^(BW_W-1).
  logic [BW_W-1:0] w_mag;
  assign w_mag  = elem_i[BW_W-1] ? $unsigned(-elem_i) : $unsigned(elem_i);
  assign w_zero = (w_mag <= {1'b0, thr_i});
`else
  assign w_zero = (elem_i == '0);
`endif

  assign w_widx = wptr_q[WIDX_W-1:0];

  always_comb begin
    wptr_d = wptr_q;
    zrun_d = zrun_q;
    if (clr_i) begin
      wptr_d = '0;
      zrun_d = '0;
    end
    if (scan_i) begin
      if (w_zero) begin
        zrun_d = zrun_q + BW_Z'(1);
      end else begin
        wptr_d = wptr_q + BW_P'(1);
        zrun_d = '0;
      end
    end
    // Runs never carry across a column boundary.
    if (last_i) begin
      zrun_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      zrun_q <= '0;
      for (int i = 0; i < NNZ; i++) begin
        enc_w_q[i] <= '0;
        enc_z_q[i] <= '0;
      end
      for (int c = 0; c <= W_COL; c++) begin
        enc_p_q[c] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      zrun_q <= zrun_d;
      if (clr_i) begin
        for (int i = 0; i < NNZ; i++) begin
          enc_w_q[i] <= '0;
          enc_z_q[i] <= '0;
        end
      end
      // wptr_d already reflects the clear on a matrix's first column.
      if (p_wr_i) begin
        enc_p_q[p_idx_i] <= wptr_d;
      end
      if (scan_i && !w_zero) begin
        enc_w_q[w_widx] <= elem_i;
        enc_z_q[w_widx] <= zrun_q;
      end
      if (final_i) begin
        enc_p_q[W_COL] <= wptr_d;
      end
    end
  end

  assign enc_w_o = enc_w_q;
  assign enc_z_o = enc_z_q;
  assign enc_p_o = enc_p_q;

endmodule
`default_nettype wire

// File: rtl/sparse_weight_encoder.sv
`default_nettype none
// ============================================================================
// Module  : sparse_weight_encoder
// Brief   : Dense int8 columns in, per-PE w/z/p compressed image out.
//           Optional magnitude pruning via SPARSE_ENC_THRESH_EN. Rev 1.0
// ============================================================================
module sparse_weight_encoder
  import sparse_enc_pkg::*;
#(
  parameter int PE_NUM = PE_NUM_DEF,
  parameter int W_ROW  = W_ROW_DEF,
  parameter int W_COL  = W_COL_DEF,
  parameter int BW_W   = 8,
  parameter int BW_P   = 7,
  parameter int BW_Z   = 3
) (
  input  wire                    clk,
  input  wire                    reset_n,
  sparse_weight_encoder_if.slave bus
);
  localparam int LROWS  = W_ROW / PE_NUM;
  localparam int NNZ    = W_ROW * W_COL / PE_NUM;
  localparam int CNT_W  = clog2_min1(W_COL + 1);
  localparam int SCAN_W = clog2_min1(LROWS);

  generate
    if (W_ROW % PE_NUM != 0) begin : g_chk_row
      $error("sparse_weight_encoder: W_ROW must be a multiple of PE_NUM");
    end
    if (!fits_bits(NNZ, BW_P)) begin : g_chk_p
      $error("sparse_weight_encoder: BW_P too narrow for W_ROW*W_COL/PE_NUM");
    end
    if (!fits_bits(LROWS - 1, BW_Z)) begin : g_chk_z
      $error("sparse_weight_encoder: BW_Z too narrow for W_ROW/PE_NUM-1");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic                   rdy_en_q;
  logic      [CNT_W-1:0]  col_cnt_q, col_cnt_d;
  logic      [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic signed [BW_W-1:0] col_buf_q [W_ROW];
`ifdef SPARSE_ENC_THRESH_EN
  logic      [BW_W-2:0]   thr_q;
`endif

  logic w_col_ready, w_accept, w_clr, w_scan, w_last, w_final;

  logic signed [BW_W-1:0] w_enc_w [PE_NUM][NNZ];
  logic        [BW_Z-1:0] w_enc_z [PE_NUM][NNZ];
  logic        [BW_P-1:0] w_enc_p [PE_NUM][W_COL+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ACCEPT;
      rdy_en_q   <= 1'b0;
      col_cnt_q  <= '0;
      scan_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      col_cnt_q  <= col_cnt_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    scan_cnt_d  = scan_cnt_q;
    w_col_ready = 1'b0;
    w_accept    = 1'b0;
    w_clr       = 1'b0;
    w_scan      = 1'b0;
    w_last      = 1'b0;
    w_final     = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        // rdy_en_q keeps col_ready low for the cycle of reset release.
        w_col_ready = rdy_en_q;
        if (bus.col_valid && rdy_en_q) begin
          w_accept   = 1'b1;
          w_clr      = (col_cnt_q == '0);
          scan_cnt_d = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_scan     = 1'b1;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        if (scan_cnt_q == SCAN_W'(LROWS - 1)) begin
          w_last = 1'b1;
          if (col_cnt_q == CNT_W'(W_COL - 1)) begin
            w_final = 1'b1;
            state_d = ST_DONE;
          end else begin
            col_cnt_d = col_cnt_q + CNT_W'(1);
            state_d   = ST_ACCEPT;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          col_cnt_d = '0;
          state_d   = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < W_ROW; r++) begin
        col_buf_q[r] <= '0;
      end
`ifdef SPARSE_ENC_THRESH_EN
      thr_q <= '0;
`endif
    end else begin
      if (w_accept) begin
        col_buf_q <= bus.col_in;
      end
`ifdef SPARSE_ENC_THRESH_EN
      if (w_clr) begin
        thr_q <= bus.prune_thr;
      end
`endif
    end
  end

  generate
    for (genvar p = 0; p < PE_NUM; p++) begin : g_lane
      logic signed [BW_W-1:0] w_col [LROWS];
      // Local row k of this PE is global row k*PE_NUM + p.
      for (genvar k = 0; k < LROWS; k++) begin : g_row
        assign w_col[k] = col_buf_q[k*PE_NUM + p];
      end

      sparse_enc_lane #(
        .W_COL (W_COL),
        .BW_W  (BW_W),
        .BW_P  (BW_P),
        .BW_Z  (BW_Z),
        .NNZ   (NNZ)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (w_clr),
        .p_wr_i  (w_accept),
        .p_idx_i (col_cnt_q),
        .scan_i  (w_scan),
        .last_i  (w_last),
        .final_i (w_final),
        .elem_i  (w_col[scan_cnt_q]),
`ifdef SPARSE_ENC_THRESH_EN
        .thr_i   (thr_q),
`endif
        .enc_w_o (w_enc_w[p]),
        .enc_z_o (w_enc_z[p]),
        .enc_p_o (w_enc_p[p])
      );
    end
  endgenerate

  assign bus.col_ready = w_col_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.enc_w     = w_enc_w;
  assign bus.enc_z     = w_enc_z;
  assign bus.enc_p     = w_enc_p;

endmodule
`default_nettype wire

// File: tb/tb_sparse_weight_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sparse_weight_encoder
// Brief   : Directed self-checking bench for sparse_weight_encoder (threshold
//           case compiled in with SPARSE_ENC_THRESH_EN). Rev 1.0
// ============================================================================
module tb_sparse_weight_encoder;
  import sparse_enc_pkg::*;

  localparam int PE_NUM = 4;
  localparam int W_ROW  = 16;
  localparam int W_COL  = 8;
  localparam int BW_W   = 8;
  localparam int BW_P   = 7;
  localparam int BW_Z   = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   edges;
  logic signed [BW_W-1:0] mat [W_COL][W_ROW];
  int   exp_p [W_COL+1];

  sparse_weight_encoder_if #(
    .PE_NUM(PE_NUM), .W_ROW(W_ROW), .W_COL(W_COL),
    .BW_W(BW_W), .BW_P(BW_P), .BW_Z(BW_Z)
  ) bus ();

  sparse_weight_encoder #(
    .PE_NUM(PE_NUM), .W_ROW(W_ROW), .W_COL(W_COL),
    .BW_W(BW_W), .BW_P(BW_P), .BW_Z(BW_Z)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mat();
    for (int c = 0; c < W_COL; c++)
      for (int r = 0; r < W_ROW; r++)
        mat[c][r] = '0;
  endtask

  task automatic check_p(input string tag, input int pe);
    for (int c = 0; c <= W_COL; c++)
      check_eq($sformatf("%s_p[%0d][%0d]", tag, pe, c), int'(bus.enc_p[pe][c]), exp_p[c]);
  endtask

  task automatic check_wz(input string tag, input int pe, input int idx,
                          input int ew, input int ez);
    check_eq($sformatf("%s_w[%0d][%0d]", tag, pe, idx), int'(bus.enc_w[pe][idx]), ew);
    check_eq($sformatf("%s_z[%0d][%0d]", tag, pe, idx), int'(bus.enc_z[pe][idx]), ez);
  endtask

  task automatic check_all_zero(input string tag);
    for (int pe = 0; pe < PE_NUM; pe++) begin
      for (int i = 0; i < NNZ_MAX; i++) check_wz(tag, pe, i, 0, 0);
      for (int c = 0; c <= W_COL; c++)
        check_eq($sformatf("%s_p[%0d][%0d]", tag, pe, c), int'(bus.enc_p[pe][c]), 0);
    end
  endtask

  // Entered at a negedge; col_valid stays high across columns. With ncols
  // short of W_COL it returns one negedge after the last accept.
  task automatic load_matrix(input int ncols, output int lat);
    int t0;
    int n;
    t0  = cyc;
    lat = -1;
    for (int c = 0; c < ncols; c++) begin
      bus.col_in    = mat[c];
      bus.col_valid = 1'b1;
      n = 0;
      while (!bus.col_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check_eq("col_ready_wait", int'(bus.col_ready), 1);
      if (c == 0) t0 = cyc;
      @(negedge clk);
    end
    bus.col_valid = 1'b0;
    if (ncols == W_COL) begin
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("out_valid_rise", int'(bus.out_valid), 1);
      lat = cyc - t0;
    end
  endtask

  task automatic ack_image();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic set_mat_b();
    clear_mat();
    mat[0][0] = 8'sd5;
    mat[0][5] = -8'sd3;
  endtask

  task automatic check_mat_b(input string tag);
    check_wz(tag, 0, 0, 5, 0);
    check_wz(tag, 1, 0, -3, 1);
    check_wz(tag, 0, 1, 0, 0);
    check_wz(tag, 2, 0, 0, 0);
    exp_p = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    check_p(tag, 0);
    check_p(tag, 1);
    exp_p = '{default: 0};
    check_p(tag, 2);
    check_p(tag, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.col_valid = 1'b0;
    bus.out_ready = 1'b0;
    for (int r = 0; r < W_ROW; r++) bus.col_in[r] = '0;
`ifdef SPARSE_ENC_THRESH_EN
    bus.prune_thr = '0;
`endif
    clear_mat();
    repeat (3) @(negedge clk);

    check_eq("rst_out_valid", int'(bus.out_valid), 0);
    check_eq("rst_col_ready", int'(bus.col_ready), 0);
    check_eq("rst_enc_p", int'(bus.enc_p[3][W_COL]), 0);
    check_eq("rst_enc_w", int'(bus.enc_w[0][0]), 0);
    reset_n = 1'b1;
    #1;
    check_eq("release_col_ready", int'(bus.col_ready), 0);
    @(negedge clk);
    check_eq("ready_after_release", int'(bus.col_ready), 1);

    // All-zero matrix and streaming latency.
    load_matrix(W_COL, edges);
    check_eq("latency", edges, W_COL * (L + 1));
    check_all_zero("A");
    ack_image();
    check_eq("ack_col_ready", int'(bus.col_ready), 1);
    check_eq("ack_out_valid", int'(bus.out_valid), 0);

    set_mat_b();
    load_matrix(W_COL, edges);
    check_mat_b("B");
    ack_image();

    // Column 3 all ones.
    clear_mat();
    for (int r = 0; r < W_ROW; r++) mat[3][r] = 8'sd1;
    load_matrix(W_COL, edges);
    exp_p = '{0, 0, 0, 0, 4, 4, 4, 4, 4};
    for (int pe = 0; pe < PE_NUM; pe++) begin
      check_p("C", pe);
      for (int i = 0; i < 4; i++) check_wz("C", pe, i, 1, 0);
      check_wz("C", pe, 4, 0, 0);
    end

    // Hold in DONE without acknowledge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("hold_out_valid_%0d", i), int'(bus.out_valid), 1);
      check_eq($sformatf("hold_col_ready_%0d", i), int'(bus.col_ready), 0);
      check_eq($sformatf("hold_p_%0d", i), int'(bus.enc_p[2][W_COL]), 4);
    end
    ack_image();
    check_eq("rel_col_ready", int'(bus.col_ready), 1);
    check_eq("rel_out_valid", int'(bus.out_valid), 0);
    check_eq("rel_kept_p", int'(bus.enc_p[1][W_COL]), 4);

    // Second matrix after C must start from a clean image.
    set_mat_b();
    load_matrix(W_COL, edges);
    check_mat_b("B2");
    ack_image();

    // Reset asserted during SCAN of column 4.
    clear_mat();
    for (int r = 0; r < W_ROW; r++) mat[3][r] = 8'sd1;
    load_matrix(5, edges);
    @(negedge clk);
    check_eq("mid_p_before_rst", int'(bus.enc_p[0][4]), 4);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_eq("mid_rst_p", int'(bus.enc_p[0][4]), 0);
    check_eq("mid_rst_w", int'(bus.enc_w[1][0]), 0);
    check_eq("mid_rst_col_ready", int'(bus.col_ready), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Scattered pattern: runs restart per column, max run, extremes.
    clear_mat();
    mat[0][12] = 8'sd9;
    mat[1][0]  = -8'sd1;
    mat[2][2]  = 8'sh80;
    mat[2][14] = 8'sd7;
    mat[7][15] = 8'sd127;
    load_matrix(W_COL, edges);
    exp_p = '{0, 1, 2, 2, 2, 2, 2, 2, 2};
    check_p("D", 0);
    check_wz("D", 0, 0, 9, 3);
    check_wz("D", 0, 1, -1, 0);
    exp_p = '{default: 0};
    check_p("D", 1);
    exp_p = '{0, 0, 0, 2, 2, 2, 2, 2, 2};
    check_p("D", 2);
    check_wz("D", 2, 0, -128, 0);
    check_wz("D", 2, 1, 7, 2);
    exp_p = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    check_p("D", 3);
    check_wz("D", 3, 0, 127, 3);
    check_wz("D", 3, 1, 0, 0);
    ack_image();

`ifdef SPARSE_ENC_THRESH_EN
    clear_mat();
    mat[0][0] = 8'sd1;
    mat[0][1] = -8'sd2;
    mat[0][2] = 8'sd3;
    mat[0][3] = 8'sh80;
    bus.prune_thr = 7'd2;
    load_matrix(W_COL, edges);
    check_eq("thr_p0", int'(bus.enc_p[0][W_COL]), 0);
    check_eq("thr_p1", int'(bus.enc_p[1][W_COL]), 0);
    check_eq("thr_p2", int'(bus.enc_p[2][W_COL]), 1);
    check_wz("thr", 2, 0, 3, 0);
    check_wz("thr", 3, 0, -128, 0);
    ack_image();
    bus.prune_thr = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
